// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: condition codes, flag bit positions
// and the handshake FSM states.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ  = 4'h0,
        NE  = 4'h1,
        CS  = 4'h2,
        CC  = 4'h3,
        MI  = 4'h4,
        PL  = 4'h5,
        VS  = 4'h6,
        VC  = 4'h7,
        HI  = 4'h8,
        LS  = 4'h9,
        GE  = 4'hA,
        LT  = 4'hB,
        GT  = 4'hC,
        LE  = 4'hD,
        AL  = 4'hE,
        RSV = 4'hF
    } cond_e;

    localparam int N_IDX = 0;
    localparam int Z_IDX = 1;
    localparam int C_IDX = 2;
    localparam int V_IDX = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // flag_write[1] selects the N,Z field, flag_write[0] selects the C,V field.
    function automatic logic [3:0] merge_flags(
        input logic [3:0] cur,
        input logic [3:0] nxt,
        input logic [1:0] wr
    );
        logic [3:0] res;
        res        = cur;
        res[N_IDX] = wr[1] ? nxt[N_IDX] : cur[N_IDX];
        res[Z_IDX] = wr[1] ? nxt[Z_IDX] : cur[Z_IDX];
        res[C_IDX] = wr[0] ? nxt[C_IDX] : cur[C_IDX];
        res[V_IDX] = wr[0] ? nxt[V_IDX] : cur[V_IDX];
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_cond_check.sv
// Purely combinational condition evaluator: maps a condition code and an NZCV
// flag set to a taken/not-taken result, flagging the reserved code.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_ex,
    output logic       cond_err
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        cond_ex  = 1'b0;
        cond_err = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            AL:      cond_ex = 1'b1;
            default: cond_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural NZCV register with same-cycle forwarding, a
// one-deep registered query/response pipeline and a saturating taken counter.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       flags_in,
    input  logic [1:0]       flag_write,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       cond,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             cond_ex,
    output logic             cond_err,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       flags_d;
    logic             cond_ex_q, cond_ex_d;
    logic             cond_err_q, cond_err_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [3:0]       flags_fwd;
    logic             eval_ex, eval_err;
    logic             accept, resp_hs;

    // Queries see this cycle's flag write, not just the registered flags.
    assign flags_fwd = merge_flags(flags_q, flags_in, flag_write);

    cond_check u_cond_check (
        .flags    (flags_fwd),
        .cond     (cond),
        .cond_ex  (eval_ex),
        .cond_err (eval_err)
    );

    assign resp_valid = (state_q == ST_RESP);
    assign resp_hs    = resp_valid & resp_ready;
    assign req_ready  = (state_q == ST_IDLE) | resp_hs;
    assign accept     = req_valid & req_ready;
    assign cond_ex    = cond_ex_q;
    assign cond_err   = cond_err_q;
    assign taken_cnt  = taken_cnt_q;

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_fwd;
        cond_ex_d   = cond_ex_q;
        cond_err_d  = cond_err_q;
        taken_cnt_d = taken_cnt_q;

        if (resp_hs && cond_ex_q && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: if (accept)     state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = accept ? ST_RESP : ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase

        // Result is captured only on acceptance, so a stalled response holds.
        if (accept) begin
            cond_ex_d  = eval_ex;
            cond_err_d = eval_err;
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and wins over any same-cycle write or query.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flags_q     <= 4'b0000;
            cond_ex_q   <= 1'b0;
            cond_err_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cond_ex_q   <= cond_ex_d;
            cond_err_q  <= cond_err_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a per-cycle reference model plus directed
// scenarios with hand-computed expectations.
module tb_cond_unit;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       flags_in;
    logic [1:0]       flag_write;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       cond;
    logic             resp_valid;
    logic             resp_ready;
    logic             cond_ex;
    logic             cond_err;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    int n_total = 0;
    int n_pass  = 0;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flags_in   (flags_in),
        .flag_write (flag_write),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .cond       (cond),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .cond_ex    (cond_ex),
        .cond_err   (cond_err),
        .flags_q    (flags_q),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit       armed = 0;
    bit [3:0] m_flags = 0;
    bit       m_valid = 0;
    bit       m_ex = 0;
    bit       m_err = 0;
    int       m_cnt = 0;

    // Even codes 0..D test a base predicate, the following odd code its inverse.
    function automatic void model_eval(input bit [3:0] f, input int code, output bit ex, output bit err);
        bit n = f[0];
        bit z = f[1];
        bit c = f[2];
        bit v = f[3];
        bit base = 0;
        err = (code == 15);
        ex  = 0;
        if (code == 14) ex = 1;
        else if (code < 14) begin
            case (code / 2)
                0: base = z;
                1: base = c;
                2: base = n;
                3: base = v;
                4: base = c && !z;
                5: base = (n == v);
                default: base = !z && (n == v);
            endcase
            ex = (code % 2 == 1) ? !base : base;
        end
    endfunction

    function automatic bit [3:0] model_merge(input bit [3:0] cur, input bit [3:0] nxt, input bit [1:0] wr);
        bit [3:0] r;
        for (int k = 0; k < 4; k++) begin
            bit sel = (k < 2) ? wr[1] : wr[0];
            r[k] = sel ? nxt[k] : cur[k];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit [3:0] fwd;
        bit       hs, rdy, ex, err;
        if (reset) begin
            m_flags = 0; m_valid = 0; m_ex = 0; m_err = 0; m_cnt = 0;
            armed   = 1;
        end else begin
            fwd = model_merge(m_flags, flags_in, flag_write);
            hs  = m_valid && resp_ready;
            rdy = !m_valid || hs;
            if (hs && m_ex && m_cnt < CNT_MAX) m_cnt++;
            if (req_valid && rdy) begin
                model_eval(fwd, int'(cond), ex, err);
                m_valid = 1; m_ex = ex; m_err = err;
            end else if (hs) begin
                m_valid = 0;
            end
            m_flags = fwd;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_resp_valid", resp_valid, m_valid);
            check("m_req_ready", req_ready, !m_valid || (m_valid && resp_ready));
            check("m_flags_q", flags_q, m_flags);
            check("m_taken_cnt", taken_cnt, m_cnt);
            if (m_valid) begin
                check("m_cond_ex", cond_ex, m_ex);
                check("m_cond_err", cond_err, m_err);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] fw, input logic [3:0] fi, input logic rv,
                         input logic [3:0] cd, input logic rr);
        flag_write = fw; flags_in = fi; req_valid = rv; cond = cd; resp_ready = rr;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_flags_q", flags_q, 4'b0000);
        check("rst_taken_cnt", taken_cnt, 0);

        // Same-cycle flag write forwarded to an EQ query.
        drive(2'b11, 4'b0010, 1'b1, 4'h0, 1'b1);
        cyc();
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("fwd_resp_valid", resp_valid, 1);
        check("fwd_cond_ex", cond_ex, 1);
        check("fwd_flags_q", flags_q, 4'b0010);
        cyc();

        // Reserved code: error, never counted.
        drive(2'b00, 4'h0, 1'b1, 4'hF, 1'b1);
        cyc();
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("rsv_cond_ex", cond_ex, 0);
        check("rsv_cond_err", cond_err, 1);
        check("rsv_taken_cnt", taken_cnt, 1);
        cyc();
        check("rsv_taken_after", taken_cnt, 1);

        // N=1,V=1: GE then LT back-to-back.
        drive(2'b11, 4'b1001, 1'b0, 4'h0, 1'b1);
        cyc();
        drive(2'b00, 4'h0, 1'b1, 4'hA, 1'b1);
        #1;
        check("b2b_ready0", req_ready, 1);
        cyc();
        drive(2'b00, 4'h0, 1'b1, 4'hB, 1'b1);
        #1;
        check("b2b_ge_ex", cond_ex, 1);
        check("b2b_ready1", req_ready, 1);
        cyc();
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("b2b_lt_ex", cond_ex, 0);
        check("b2b_lt_valid", resp_valid, 1);
        cyc();

        // HI with C=1,Z=0, then stall while Z gets set.
        drive(2'b11, 4'b0100, 1'b1, 4'h8, 1'b0);
        cyc();
        drive(2'b11, 4'b0110, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_cond_ex", cond_ex, 1);
            check("stall_req_ready", req_ready, 0);
            cyc();
        end
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("stall_release_ready", req_ready, 1);
        check("stall_flags_q", flags_q, 4'b0110);
        cyc();

        // Sweep every code with assorted flags and partial writes, back-to-back.
        for (int i = 0; i < 16; i++) begin
            drive(2'(i % 4), 4'((i * 7 + 3) % 16), 1'b1, 4'(i), 1'b1);
            cyc();
        end
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        cyc();

        // Reset during a pending response discards it and a same-cycle write/query.
        drive(2'b00, 4'h0, 1'b1, 4'hE, 1'b0);
        cyc();
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        check("prerst_resp_valid", resp_valid, 1);
        reset = 1'b1;
        drive(2'b11, 4'hF, 1'b1, 4'hE, 1'b0);
        cyc();
        reset = 1'b0;
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_flags_q", flags_q, 4'b0000);
        check("midrst_taken_cnt", taken_cnt, 0);
        check("midrst_req_ready", req_ready, 1);

        // Five AL queries: counter saturates at 3.
        drive(2'b00, 4'h0, 1'b1, 4'hE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("sat_taken_cnt", taken_cnt, (i < 3) ? i : 3);
        end
        drive(2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
        cyc();
        check("sat_final", taken_cnt, 3);
        cyc();
        check("sat_hold", taken_cnt, 3);
        check("sat_idle_valid", resp_valid, 0);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
